// File: rtl/bus_trace_if.sv
// bus_trace_if: capture bus and debug register bus bundle for bus_trace.
//   master : drives capture sample/strobe and register select/strobes/data
//   slave  : the trace buffer; returns registered read data and cap_done
interface bus_trace_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16,
    parameter int unsigned FW = 4
) ();
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_dat;
    logic [FW-1:0] flags;
    logic          cap_wr;
    logic [3:0]    reg_sel;
    logic          reg_wr;
    logic [7:0]    reg_wdat;
    logic          reg_rd;
    logic [7:0]    reg_rdat;
    logic          cap_done;

    modport master (
        output cap_addr, cap_dat, flags, cap_wr,
        output reg_sel, reg_wr, reg_wdat, reg_rd,
        input  reg_rdat, cap_done
    );

    modport slave (
        input  cap_addr, cap_dat, flags, cap_wr,
        input  reg_sel, reg_wr, reg_wdat, reg_rd,
        output reg_rdat, cap_done
    );
endinterface

// File: rtl/bus_trace.sv
// bus_trace: circular bus-capture trace buffer with arm/trigger/post-trigger
// control and byte-serial readout through an 8-bit register window.
//   clk25 : system clock (rising edge)
//   res   : asynchronous active-high reset
//   bus   : bus_trace_if.slave -- capture sample + strobe, register bus,
//           registered read data (reg_rdat) and cap_done (state == DONE)
module bus_trace #(
    parameter int unsigned AW         = 16,
    parameter int unsigned DW         = 16,
    parameter int unsigned FW         = 4,
    parameter int unsigned DEPTH_LOG2 = 9
) (
    input logic        clk25,
    input logic        res,
    bus_trace_if.slave bus
);
    localparam int unsigned EW    = AW + DW + FW;
    localparam int unsigned NB    = (EW + 7) / 8;
    localparam int unsigned NBW   = NB * 8;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [2:0]    LAST_BYTE = 3'(NB - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StTrig  = 2'd2,
        StDone  = 2'd3
    } state_e;

    state_e        r_state;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [2:0]    r_byte_idx;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_trig_idx;
    logic [AW-1:0] r_trig_addr;
    logic [15:0]   r_post_cnt;
    logic [15:0]   r_post_left;
    logic          r_wrapped;
    logic          r_tmode;
    logic [7:0]    r_rdat;
    logic [EW-1:0] r_mem [DEPTH];
    logic [EW-1:0] r_ram_q;

    logic          w_ctrl_wr, w_clear, w_arm, w_stop, w_man;
    logic          w_capturing, w_store, w_match, w_trig;
    logic [PW-1:0] w_wr_ptr_n;
    logic          w_wrapped_n;
    logic [PW-1:0] w_done_rd_ptr;
    logic          w_readable, w_data_rd, w_rdptr_wr;
    logic [PW-1:0] w_rdptr_new;
    logic [NBW-1:0] w_ram_bytes;
    logic [15:0]   w_ta16, w_rd16, w_ti16, w_cnt16;
    logic [7:0]    w_rdat_n;

    always_comb begin
        w_ctrl_wr   = bus.reg_wr && (bus.reg_sel == 4'd0);
        w_clear     = w_ctrl_wr && bus.reg_wdat[2];
        w_arm       = w_ctrl_wr && bus.reg_wdat[0];
        w_stop      = w_ctrl_wr && bus.reg_wdat[1];
        w_man       = w_ctrl_wr && bus.reg_wdat[3];
        w_capturing = (r_state == StArmed) || (r_state == StTrig);
        // Clear and arm both discard a sample offered in the same cycle.
        w_store     = bus.cap_wr && w_capturing && !w_clear && !w_arm;
        w_match     = r_tmode ? (bus.cap_addr == r_trig_addr) : 1'b1;
        w_trig      = (r_state == StArmed) && ((bus.cap_wr && w_match) || w_man);
        w_wr_ptr_n  = w_store ? r_wr_ptr + 1'b1 : r_wr_ptr;
        w_wrapped_n = r_wrapped || (w_store && (&r_wr_ptr));
        // Oldest entry, accounting for a sample stored on the DONE transition.
        w_done_rd_ptr = w_wrapped_n ? w_wr_ptr_n : '0;
        w_readable  = (r_state == StIdle) || (r_state == StDone);
        w_data_rd   = bus.reg_rd && (bus.reg_sel == 4'd8) && w_readable;
        w_rdptr_wr  = bus.reg_wr && ((bus.reg_sel == 4'd9) || (bus.reg_sel == 4'd10))
                      && w_readable;
        w_ta16      = 16'(r_trig_addr);
        w_rd16      = 16'(r_rd_ptr);
        w_ti16      = 16'(r_trig_idx);
        w_cnt16     = 16'(r_count);
        w_rdptr_new = (bus.reg_sel == 4'd9) ? PW'({w_rd16[15:8], bus.reg_wdat})
                                            : PW'({bus.reg_wdat, w_rd16[7:0]});
        w_ram_bytes = NBW'(r_ram_q);
    end

    always_comb begin
        w_rdat_n = 8'h00;
        case (bus.reg_sel)
            4'd0:  w_rdat_n = {3'b000, r_wrapped, 2'b00, r_state};
            4'd1:  w_rdat_n = w_ta16[7:0];
            4'd2:  w_rdat_n = w_ta16[15:8];
            4'd3:  w_rdat_n = {7'd0, r_tmode};
            4'd4:  w_rdat_n = r_post_cnt[7:0];
            4'd5:  w_rdat_n = r_post_cnt[15:8];
            4'd6:  w_rdat_n = w_ti16[7:0];
            4'd7:  w_rdat_n = w_ti16[15:8];
            4'd8:  w_rdat_n = w_readable ? w_ram_bytes[{r_byte_idx, 3'b000} +: 8] : 8'h00;
            4'd9:  w_rdat_n = w_rd16[7:0];
            4'd10: w_rdat_n = w_rd16[15:8];
            4'd11: w_rdat_n = w_cnt16[7:0];
            4'd12: w_rdat_n = w_cnt16[15:8];
            default: w_rdat_n = 8'h00;
        endcase
    end

    // Buffer RAM: synchronous write, registered read of the entry at rd_ptr.
    always_ff @(posedge clk25) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= {bus.flags, bus.cap_dat, bus.cap_addr};
        end
        r_ram_q <= r_mem[r_rd_ptr];
    end

    always_ff @(posedge clk25 or posedge res) begin
        if (res) begin
            r_state     <= StIdle;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_byte_idx  <= '0;
            r_count     <= '0;
            r_trig_idx  <= '0;
            r_trig_addr <= '0;
            r_post_cnt  <= '0;
            r_post_left <= '0;
            r_wrapped   <= 1'b0;
            r_tmode     <= 1'b0;
            r_rdat      <= 8'h00;
        end else begin
            if (bus.reg_rd) begin
                r_rdat <= w_rdat_n;
            end

            // Configuration registers are writable in any state and survive clear.
            if (bus.reg_wr) begin
                case (bus.reg_sel)
                    4'd1: r_trig_addr <= AW'({w_ta16[15:8], bus.reg_wdat});
                    4'd2: r_trig_addr <= AW'({bus.reg_wdat, w_ta16[7:0]});
                    4'd3: r_tmode <= bus.reg_wdat[0];
                    4'd4: r_post_cnt[7:0] <= bus.reg_wdat;
                    4'd5: r_post_cnt[15:8] <= bus.reg_wdat;
                    default: ;
                endcase
            end

            if (w_clear) begin
                r_state     <= StIdle;
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_byte_idx  <= '0;
                r_count     <= '0;
                r_trig_idx  <= '0;
                r_post_left <= '0;
                r_wrapped   <= 1'b0;
            end else if (w_arm) begin
                r_state    <= StArmed;
                r_wr_ptr   <= '0;
                r_count    <= '0;
                r_trig_idx <= '0;
                r_wrapped  <= 1'b0;
                r_byte_idx <= '0;
            end else begin
                if (w_store) begin
                    r_wr_ptr <= w_wr_ptr_n;
                    if (r_count != CNT_FULL) begin
                        r_count <= r_count + 1'b1;
                    end
                end
                r_wrapped <= w_wrapped_n;

                if (w_data_rd) begin
                    if (r_byte_idx == LAST_BYTE) begin
                        r_byte_idx <= '0;
                        r_rd_ptr   <= r_rd_ptr + 1'b1;
                    end else begin
                        r_byte_idx <= r_byte_idx + 1'b1;
                    end
                end
                if (w_rdptr_wr) begin
                    r_rd_ptr   <= w_rdptr_new;
                    r_byte_idx <= '0;
                end

                case (r_state)
                    StArmed: begin
                        if (w_trig) begin
                            r_trig_idx  <= r_wr_ptr;
                            r_post_left <= r_post_cnt;
                        end
                        if (w_stop || (w_trig && (r_post_cnt == 16'd0))) begin
                            r_state    <= StDone;
                            r_rd_ptr   <= w_done_rd_ptr;
                            r_byte_idx <= '0;
                        end else if (w_trig) begin
                            r_state <= StTrig;
                        end
                    end
                    StTrig: begin
                        if (w_store) begin
                            r_post_left <= r_post_left - 16'd1;
                        end
                        if (w_stop || (w_store && (r_post_left == 16'd1))) begin
                            r_state    <= StDone;
                            r_rd_ptr   <= w_done_rd_ptr;
                            r_byte_idx <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.reg_rdat = r_rdat;
    assign bus.cap_done = (r_state == StDone);
endmodule

// File: doc/bus_trace.md
Name: bus_trace

Overview:
- Parametrised bus-capture trace buffer for the BK0010 debug path.
- Samples {flags, data, address} on every qualified CPU bus write into a circular block-RAM buffer.
- Supports arm/trigger/post-trigger control, address-match or manual trigger, and overflow (wrap) tracking.
- Readout is byte-serial through an 8-bit register window on the existing debug register bus, oldest entry first.

Parameters:
- AW, 16, captured address width (1..16).
- DW, 16, captured data width (1..32).
- FW, 4, captured flag width (1..8).
- DEPTH_LOG2, 9, log2 of buffer depth in entries (4..16).
- Derived: EW = AW+DW+FW bits per entry; NB = ceil(EW/8) bytes per entry; DEPTH = 2^DEPTH_LOG2.

Ports:
- clk25  in  1  system clock; all logic on its rising edge.
- res  in  1  asynchronous active-high reset.
- cap_addr  in  AW  bus address to capture.
- cap_dat  in  DW  bus data to capture.
- flags  in  FW  bus qualifier flags to capture.
- cap_wr  in  1  synchronous capture strobe; one sample per high cycle.
- reg_sel  in  4  register select.
- reg_wr  in  1  register write strobe, one-cycle pulse.
- reg_wdat  in  8  register write data.
- reg_rd  in  1  register read strobe, one-cycle pulse.
- reg_rdat  out  8  registered read data.
- cap_done  out  1  high while state is DONE.

Behaviour:
- Reset: state IDLE; wr_ptr, rd_ptr, byte_idx, count, trig_idx, trig_addr, post_cnt, post_left, wrapped, tmode all 0; reg_rdat 0; cap_done 0.
- States: IDLE=0, ARMED=1, TRIGGERED=2, DONE=3.
- Registers, reg_sel:
  - 0 CTRL: write bit0 arm, bit1 stop, bit2 clear, bit3 manual trigger. Read {3'b0, wrapped, 2'b0, state[1:0]}.
  - 1/2 TRIG_ADDR lo/hi (r/w).
  - 3 TMODE: bit0 address-match enable (r/w).
  - 4/5 POST_CNT lo/hi (r/w): entries to capture after the trigger entry.
  - 6/7 TRIG_IDX lo/hi (ro).
  - 8 DATA (ro).
  - 9/10 RD_PTR lo/hi (r/w). A write to either also clears byte_idx.
  - 11/12 COUNT lo/hi (ro).
  - 13..15: read 0, writes ignored.
  - Bits above AW or DEPTH_LOG2 read 0.
- reg_rdat updates one cycle after the reg_rd pulse and holds until the next read.
- Capture: in ARMED or TRIGGERED, each cycle with cap_wr=1 writes {flags,cap_dat,cap_addr} (address in LSBs) at wr_ptr. Then wr_ptr+1 mod DEPTH. count increments, saturating at DEPTH. wrapped is set when wr_ptr wraps DEPTH-1 -> 0. cap_wr is ignored in IDLE and DONE.
- Trigger condition (ARMED only): cap_wr & (tmode[0] ? cap_addr==trig_addr : 1).
  - On trigger, the sample is written, trig_idx = its index, and post_left = post_cnt.
  - Next state is TRIGGERED, or DONE if post_cnt==0.
- Manual trigger in ARMED: trig_idx = current wr_ptr, post_left = post_cnt. Next state is TRIGGERED, or DONE if post_cnt==0. A cap_wr in the same cycle is the trigger entry.
- TRIGGERED: each stored sample decrements post_left. The sample that brings it to 0 is stored, then the state becomes DONE.
- Arm (any state): ARMED; wr_ptr, count, trig_idx, wrapped and byte_idx cleared. A cap_wr in the same cycle is not stored.
- Stop (any state except IDLE): DONE next cycle. A cap_wr in the same cycle is stored.
- Clear: IDLE; all pointers and counters cleared; config registers kept.
- Priority within one CTRL write: clear > arm > stop > manual trigger.
- Entering DONE (any path): rd_ptr = wrapped ? wr_ptr : 0 (the oldest entry); byte_idx = 0.
- DATA read, IDLE/DONE only:
  - Returns byte byte_idx of entry rd_ptr; bits above EW in the last byte are 0.
  - byte_idx increments; after byte NB-1 it becomes 0 and rd_ptr = rd_ptr+1 mod DEPTH.
  - The entry is latched from synchronous RAM; the latch is valid 2 cycles after any rd_ptr change.
  - Successive DATA reads must be spaced >= 3 cycles apart.
- DATA read in ARMED/TRIGGERED returns 0 and advances nothing.
- RD_PTR writes are ignored in ARMED/TRIGGERED.
- Reset asserted mid-capture or mid-readout returns everything to reset values immediately. Buffer RAM contents are undefined.

Test Plan:
- Reset, read CTRL and COUNT -> 0x00, 0x00, 0x00; cap_done=0.
- DEPTH_LOG2=4, TMODE=0, POST_CNT=3, arm, cap_wr with addr 0x1000..0x1003 -> trigger at entry 0, DONE after 4 samples; COUNT=4, TRIG_IDX=0, cap_done=1.
- TMODE=1, TRIG_ADDR=0x0177, POST_CNT=2, arm, write 20 samples with addr 0x0170+i -> trig_idx=7, DONE after sample 9; wrapped=0; COUNT=10.
- DEPTH=16, POST_CNT=0xFFFF, arm, 20 writes, stop -> wrapped=1, COUNT=16, rd_ptr=4; first DATA bytes return entry of sample 4 (AW=DW=16, FW=4: NB=5, byte4 = flags in [3:0], upper nibble 0).
- Arm and cap_wr in the same cycle -> COUNT=0. Stop and cap_wr in the same cycle -> sample stored, COUNT+1.
- Assert res during TRIGGERED -> state 0, COUNT 0, reg_rdat 0 on the next read. DATA read while ARMED -> 0x00, rd_ptr unchanged.
